trap_sequencer: RTL
===================

Name: trap_sequencer

Overview:
- Sequences machine-mode interrupt entry and `mret` return for the three-stage pipeline.
- Synchronises and latches the external and timer interrupt requests, and checks the enables from the CSR file.
- Flushes the pipeline, writes mepc/mcause/mstatus through the CSR write port, then redirects fetch to the trap vector.
- Sits between the interrupt sources, the CSR register file and the PC-select mux in Processor.

Parameters:
- XLEN, 32, datapath and CSR width.
- SYNC_STAGES, 2, number of synchroniser flops on each interrupt input (minimum 2).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ext_irq  in  1  external interrupt request, asynchronous; a pulse of at least 1 clock is captured
- tmr_irq  in  1  timer interrupt request, asynchronous level
- mstatus_mie  in  1  current mstatus.MIE
- mstatus_mpie  in  1  current mstatus.MPIE
- mie_meie  in  1  mie.MEIE
- mie_mtie  in  1  mie.MTIE
- mtvec  in  XLEN  current mtvec
- mepc  in  XLEN  current mepc
- epc_in  in  XLEN  PC of the oldest uncommitted instruction (execute stage)
- mret_valid  in  1  mret decoded in the execute stage
- stall_in  in  1  pipeline stalled (load-use or memory)
- flush  out  1  kill fetch/decode/execute
- redirect  out  1  PC mux selects redirect_pc
- redirect_pc  out  XLEN  new fetch PC
- csr_we  out  1  CSR trap-write strobe
- mepc_wdata  out  XLEN  value for mepc
- mcause_wdata  out  XLEN  value for mcause
- mstatus_mie_wdata  out  1  new mstatus.MIE
- mstatus_mpie_wdata  out  1  new mstatus.MPIE
- busy  out  1  sequence in progress; blocks decode

Behaviour:
- Reset:
  - All outputs 0.
  - FSM goes to IDLE; pending bits, synchronisers and the epc register clear.
  - Reset asserted mid-sequence aborts the sequence with no CSR write.
- Synchronisation and latching:
  - Each irq passes through SYNC_STAGES flops.
  - ext_pend is set on the synchronised rising edge of ext_irq and held until the trap is taken.
  - tmr_pend follows the synchronised tmr_irq level.
- take = mstatus_mie & ((ext_pend & mie_meie) | (tmr_pend & mie_mtie)) & !stall_in.
- Priority: external over timer.
  - mcause = 32'h8000000B (external) or 32'h80000007 (timer).
  - The cause is latched at the decision cycle.
- FSM:
  - IDLE:
    - If mret_valid: same cycle, redirect=1, redirect_pc=mepc, csr_we=1, MIE<=mstatus_mpie, MPIE<=1. Stay in IDLE.
    - Else if take: latch cause and epc_in, go to FLUSH.
  - FLUSH: flush=1, busy=1; go to SAVE.
  - SAVE: csr_we=1, mepc_wdata=latched epc, mcause_wdata=latched cause, MPIE<=mstatus_mie, MIE<=0, busy=1; go to VECTOR.
  - VECTOR: redirect=1, flush=1, redirect_pc=trap target, busy=1. Clear ext_pend if the cause was external. Go to IDLE.
- Latency: decision at cycle T; flush at T+1; CSR write at T+2; redirect at T+3. The first vector instruction is fetched at T+4.
- Simultaneous events:
  - mret_valid and take in the same cycle: mret wins, and the interrupt is re-evaluated next cycle against the new MIE.
  - ext_irq edge arriving during a sequence stays pending.
- Trap target (baseline): {mtvec[XLEN-1:2], 2'b00}. Address arithmetic wraps modulo 2^XLEN.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: when mtvec[1:0]==2'b01, redirect_pc = {mtvec[XLEN-1:2],2'b00} + 4*cause_code (external gives base+0x2C, timer gives base+0x1C). Any other mode uses the base address.
- Undefined: always direct mode; mtvec[1:0] are ignored.

Decomposition:
- Package trap_pkg:
  - FSM enum trap_state_t {IDLE, FLUSH, SAVE, VECTOR}.
  - Constants MCAUSE_MEI=32'h8000000B, MCAUSE_MTI=32'h80000007, CODE_MEI=11, CODE_MTI=7.
- One sub-module irq_sync: parameterised SYNC_STAGES synchroniser plus rising-edge detector, instantiated once per source.

Test Plan:
- ext_irq 5 ns pulse, MIE=1, MEIE=1, epc_in=0x40, mtvec=0x100 -> flush at T+1; csr_we at T+2 with mepc=0x40, mcause=0x8000000B, MIE=0, MPIE=1; redirect to 0x100 at T+3.
- tmr_irq and ext_irq together, both enabled -> mcause=0x8000000B. After mret, mstatus MIE is restored to 1, then a second trap is taken with mcause=0x80000007.
- mret_valid with mepc=0x44, MPIE=1 -> same cycle redirect=1, redirect_pc=0x44, MIE<=1, MPIE<=1.
- ext_irq with mstatus_mie=0 -> no trap while disabled and ext_pend held. After MIE is set to 1, the trap fires within 1 cycle.
- stall_in=1 during a pending irq -> no decision until stall_in drops.
- Reset asserted during SAVE -> outputs 0 and no further csr_we. With TRAP_VECTORED_EN and mtvec=0x101, a timer trap redirects to 0x11C.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SAVE   = 2'd2,
    VECTOR = 2'd3
  } trap_state_t;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
  localparam int unsigned CODE_MEI   = 11;
  localparam int unsigned CODE_MTI   = 7;
  localparam int unsigned CODE_W     = 4;

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// Multi-flop synchroniser for one interrupt line; emits either the
// synchronised level or a one-cycle pulse on its rising edge.
module irq_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_DETECT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_level;
    end
  end

  assign o_out = EDGE_DETECT ? (w_level & ~r_prev) : w_level;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry / mret sequencer for the three-stage pipeline.
// Optional build macro TRAP_VECTORED_EN enables vectored mtvec mode (mtvec[1:0]==2'b01).
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic            mie_meie,
  input  logic            mie_mtie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] epc_in,
  input  logic            mret_valid,
  input  logic            stall_in,
  output logic            flush,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_we,
  output logic [XLEN-1:0] mepc_wdata,
  output logic [XLEN-1:0] mcause_wdata,
  output logic            mstatus_mie_wdata,
  output logic            mstatus_mpie_wdata,
  output logic            busy
);

  trap_state_t       r_state;
  trap_state_t       w_next;
  logic              r_ext_pend;
  logic              r_cause_ext;
  logic [XLEN-1:0]   r_epc;

  logic              w_ext_rise;
  logic              w_tmr_pend;
  logic              w_take_ext;
  logic              w_take;
  logic              w_latch;
  logic              w_clr_ext;
  logic [CODE_W-1:0] w_code;
  logic [XLEN-1:0]   w_cause_val;
  logic [XLEN-1:0]   w_base;
  logic [XLEN-1:0]   w_target;
  logic              w_unused;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b1)) u_ext_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (ext_irq),
    .o_out   (w_ext_rise)
  );

  irq_sync #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DETECT(1'b0)) u_tmr_sync (
    .clock   (clock),
    .reset   (reset),
    .i_async (tmr_irq),
    .o_out   (w_tmr_pend)
  );

  // External wins over timer when both are enabled and pending.
  assign w_take_ext  = r_ext_pend & mie_meie;
  assign w_take      = mstatus_mie & (w_take_ext | (w_tmr_pend & mie_mtie)) & ~stall_in;

  assign w_code      = r_cause_ext ? CODE_W'(CODE_MEI) : CODE_W'(CODE_MTI);
  assign w_cause_val = {1'b1, (XLEN-1)'(w_code)};
  assign w_base      = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  assign w_target = (mtvec[1:0] == 2'b01) ? (w_base + (XLEN'(w_code) << 2)) : w_base;
  assign w_unused = 1'b0;
`else
  assign w_target = w_base;
  assign w_unused = ^mtvec[1:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ext_pend  <= 1'b0;
      r_cause_ext <= 1'b0;
      r_epc       <= '0;
    end else begin
      r_state    <= w_next;
      // A fresh edge during the clearing cycle keeps the request pending.
      r_ext_pend <= w_ext_rise | (r_ext_pend & ~w_clr_ext);
      if (w_latch) begin
        r_cause_ext <= w_take_ext;
        r_epc       <= epc_in;
      end
    end
  end

  always_comb begin
    w_next             = r_state;
    flush              = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = '0;
    csr_we             = 1'b0;
    mepc_wdata         = '0;
    mcause_wdata       = '0;
    mstatus_mie_wdata  = 1'b0;
    mstatus_mpie_wdata = 1'b0;
    busy               = 1'b0;
    w_latch            = 1'b0;
    w_clr_ext          = 1'b0;
    case (r_state)
      IDLE: begin
        // mret takes precedence; a pending interrupt re-evaluates next cycle.
        if (mret_valid && !reset) begin
          redirect           = 1'b1;
          redirect_pc        = mepc;
          csr_we             = 1'b1;
          mstatus_mie_wdata  = mstatus_mpie;
          mstatus_mpie_wdata = 1'b1;
        end else if (w_take) begin
          w_latch = 1'b1;
          w_next  = FLUSH;
        end
      end
      FLUSH: begin
        flush  = 1'b1;
        busy   = 1'b1;
        w_next = SAVE;
      end
      SAVE: begin
        csr_we             = 1'b1;
        mepc_wdata         = r_epc;
        mcause_wdata       = w_cause_val;
        mstatus_mie_wdata  = 1'b0;
        mstatus_mpie_wdata = mstatus_mie;
        busy               = 1'b1;
        w_next             = VECTOR;
      end
      VECTOR: begin
        redirect    = 1'b1;
        flush       = 1'b1;
        redirect_pc = w_target;
        busy        = 1'b1;
        w_clr_ext   = r_cause_ext;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
